// File: rtl/encode_ctrl.sv
// Column-serial parity encoder sequencer.
// Holds an N-column generator matrix and, for each accepted K-bit info word,
// walks the single-column parity encoder across all N columns (one per clock),
// assembling an N-bit codeword that is offered on a valid/ready output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer side (in_valid/in_info, out_valid/out_code) holds
// its data stable while valid is high and ready is low.

// Single-column parity: XOR-reduce of the info word masked by one column.
module encode #(
   parameter int K = 6
) (
   input  logic [K-1:0] info_bits,
   input  logic [K-1:0] generator_col,
   output logic         code_bit
);

   // Parity of the selected info bits
   assign code_bit = ^(info_bits & generator_col);

endmodule

module encode_ctrl #(
   parameter  int N  = 11,
   parameter  int K  = 6,
   localparam int AW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [K-1:0]  cfg_col,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [K-1:0]  in_info,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_code,
   output logic          busy
);

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [AW-1:0] col_idx;
   logic [K-1:0]  info;
   logic [K-1:0]  store [N];
   logic          code_bit;

   encode #(.K(K)) u_encode (
      .info_bits     (info),
      .generator_col (store[col_idx]),
      .code_bit      (code_bit)
   );

   // Column store: writable only while idle so a codeword sees one matrix
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            store[i] <= '0;
         end
      end else if (state == IDLE && cfg_we && cfg_addr <= LAST) begin
         store[cfg_addr] <= cfg_col;
      end
   end

   // Sequencer: accept word, step through N columns, hold codeword until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         col_idx   <= '0;
         info      <= '0;
         out_code  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  info     <= in_info;
                  col_idx  <= '0;
                  out_code <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               out_code[col_idx] <= code_bit;
               if (col_idx == LAST) begin
                  col_idx   <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  col_idx <= col_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               col_idx   <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encode_ctrl.sv
// Bench for encode_ctrl: behavioural codeword model, per-cycle output compare,
// transaction scoreboard, directed scenarios and a randomized soak.
module tb_encode_ctrl;

   localparam int N  = 11;
   localparam int K  = 6;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [K-1:0]  cfg_col;
   logic          in_valid;
   logic          in_ready;
   logic [K-1:0]  in_info;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_code;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   encode_ctrl #(.N(N), .K(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_col   (cfg_col),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_info   (in_info),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .busy      (busy)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [K-1:0] m_mat [N];
   int           m_phase;        // 0 idle, 1 encoding, 2 holding result
   int           m_cnt;          // edges since acceptance
   logic [N-1:0] m_full;         // complete codeword for the current word
   logic [N-1:0] m_shown;        // bits visible on out_code so far
   logic [N-1:0] exp_q[$];       // codewords awaiting consumer handshake
   int           acc_q[$];       // cycle numbers of input acceptances

   function automatic logic [N-1:0] model_code(input logic [K-1:0] info);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = ^(info & m_mat[i]);
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) m_mat[i] = '0;
         m_phase = 0;
         m_cnt   = 0;
         m_full  = '0;
         m_shown = '0;
         exp_q.delete();
      end else begin
         logic [31:0] mask;
         cyc++;
         if (m_phase == 0) begin
            if (cfg_we && int'(cfg_addr) < N) m_mat[cfg_addr] = cfg_col;
            if (in_valid) begin
               acc_q.push_back(cyc);
               m_full  = model_code(in_info);
               m_shown = '0;
               m_cnt   = 0;
               m_phase = 1;
               exp_q.push_back(m_full);
            end
         end else if (m_phase == 1) begin
            m_cnt++;
            mask    = (32'd1 << m_cnt) - 32'd1;
            m_shown = m_full & mask[N-1:0];
            if (m_cnt == N) m_phase = 2;
         end else begin
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("sb_unexpected", 1, 0);
               end else begin
                  check("sb_code", 32'(out_code), 32'(exp_q.pop_front()));
               end
               m_phase = 0;
            end
         end
      end
   end

   // compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      check("in_ready",  32'(in_ready),  32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("busy",      32'(busy),      32'(m_phase != 0));
      check("out_code",  32'(out_code),  32'(m_shown));
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_write(input int addr, input logic [K-1:0] col);
      cfg_we   = 1'b1;
      cfg_addr = AW'(addr);
      cfg_col  = col;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      if (!out_valid) check("timeout_out_valid", 0, 1);
   endtask

   task automatic encode_word(input logic [K-1:0] info, output int lat, output logic [N-1:0] code);
      in_valid = 1'b1;
      in_info  = info;
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
      code      = out_code;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) check("timeout_in_ready", 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int           lat;
      logic [N-1:0] code;
      logic [K-1:0] cols [N];

      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_col = '0;
      in_valid = 1'b0; in_info = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_in_ready",  32'(in_ready),  1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy",      32'(busy),      0);
      check("rst_out_code",  32'(out_code),  0);
      rst = 1'b0;
      tick();

      // empty matrix gives all-zero codeword
      encode_word(6'b111111, lat, code);
      check("zero_lat",  lat, 11);
      check("zero_code", 32'(code), 32'h000);

      // load the reference matrix
      for (int i = 0; i < 6; i++) cols[i] = K'(1 << i);
      cols[6] = 6'b111111; cols[7] = 6'b000111; cols[8] = 6'b111000;
      cols[9] = 6'b101010; cols[10] = 6'b010101;
      for (int i = 0; i < N; i++) do_write(i, cols[i]);

      encode_word(6'b111111, lat, code);
      check("m1_lat",  lat, 11);
      check("m1_code", 32'(code), 32'h7BF);

      // back-to-back words with consumer always ready
      acc_q.delete();
      in_valid = 1'b1; in_info = 6'b000001; out_ready = 1'b1;
      for (int n = 0; n < 60 && acc_q.size() < 3; n++) begin
         tick();
         if (out_valid) check("b2b_code", 32'(out_code), 32'h4C1);
      end
      in_valid = 1'b0;
      if (acc_q.size() < 3) begin
         check("b2b_accepts", acc_q.size(), 3);
      end else begin
         check("b2b_gap1", acc_q[1] - acc_q[0], 13);
         check("b2b_gap2", acc_q[2] - acc_q[1], 13);
      end
      wait_idle();
      out_ready = 1'b0;

      // consumer stalls for 5 cycles; new words are refused
      in_valid = 1'b1; in_info = 6'b111111;
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
      for (int n = 0; n < 5; n++) begin
         in_valid = 1'b1; in_info = 6'b000001;
         tick();
         check("hold_valid", 32'(out_valid), 1);
         check("hold_ready", 32'(in_ready),  0);
         check("hold_code",  32'(out_code),  32'h7BF);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_ready", 32'(in_ready),  1);
      check("release_valid", 32'(out_valid), 0);

      // column 7 write mid-encode is ignored
      in_valid = 1'b1; in_info = 6'b111111;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      do_write(7, 6'b000000);
      wait_valid(lat);
      check("runwr_code", 32'(out_code), 32'h7BF);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // out-of-range address in idle is ignored
      do_write(11, 6'b000000);
      encode_word(6'b111111, lat, code);
      check("oor_code", 32'(code), 32'h7BF);

      // idle write of column 7 takes effect
      do_write(7, 6'b000000);
      encode_word(6'b111111, lat, code);
      check("col7_code", 32'(code), 32'h73F);

      // write and acceptance on the same idle edge: new column is used
      cfg_we = 1'b1; cfg_addr = 4'd7; cfg_col = 6'b000111;
      in_valid = 1'b1; in_info = 6'b111111;
      tick();
      cfg_we = 1'b0; in_valid = 1'b0;
      wait_valid(lat);
      check("same_edge_code", 32'(out_code), 32'h7BF);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // reset mid-encode aborts and clears the store
      in_valid = 1'b1; in_info = 6'b111111;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready",  32'(in_ready),  1);
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_busy",      32'(busy),      0);
      check("abort_out_code",  32'(out_code),  0);
      tick();
      rst = 1'b0;
      encode_word(6'b111111, lat, code);
      check("post_rst_code", 32'(code), 32'h000);

      // randomized soak
      for (int n = 0; n < 600; n++) begin
         cfg_we    = ($urandom_range(0, 3) == 0);
         cfg_addr  = AW'($urandom_range(0, 15));
         cfg_col   = K'($urandom_range(0, 63));
         in_valid  = ($urandom_range(0, 1) == 1);
         in_info   = K'($urandom_range(0, 63));
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
         tick();
      end
      cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) tick();
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
